ring_buffer_burst_ctrl: RTL
===========================

// Module: ring_buffer_burst_ctrl
// PURPOSE
//  Sequences DMA bursts into the first-stage lane ring buffer. Admits a burst only when the ring
//  has room for a whole burst, and counts beats to BURST_LENGTH. Tracks word occupancy from lane
//  writes and single-word reads, and signals job completion once all bursts are written and the
//  ring has drained. Sits between the DMA read engine and the ring buffer write port.
// PARAMETERS
//  NUM_LANE      4    words per DMA beat (ring write width)
//  BURST_LENGTH  128  beats per DMA burst
//  CAPACITY      512  ring capacity in words; must be >= NUM_LANE*BURST_LENGTH
//  CNT_W         16   width of job burst counter
// PORTS
//  clk             in   1                    clock
//  rst             in   1                    async reset, active-high
//  start           in   1                    pulse: begin job (sampled in IDLE only)
//  total_bursts    in   CNT_W                bursts in job, latched on accepted start
//  busy            out  1                    high in any state except IDLE
//  done            out  1                    1-cycle pulse at job completion
//  dma_req         out  1                    burst request, held until dma_ack
//  dma_ack         in   1                    DMA accepted request
//  dma_beat_valid  in   1                    one NUM_LANE-word beat from DMA this cycle
//  buf_wen         out  1                    ring write enable (combinational)
//  buf_consume     in   1                    one word read from ring this cycle
//  occupancy       out  $clog2(CAPACITY)+1   words currently held in ring
//  err_overflow    out  1                    sticky: beat arrived with no room
//  perf_stall_cyc  out  32                   cycles stalled waiting for space (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, dma_req, err_overflow=0; occupancy, counters=0.
//    Reset mid-job abandons the job. In-flight beats are lost and no done is produced.
//  - Burst size BW = NUM_LANE*BURST_LENGTH words.
//  - FSM states: IDLE, SPACE, REQ, XFER, DRAIN, DONE.
//    IDLE : on start, latch total_bursts into bursts_left.
//           ->DONE if total_bursts==0, else ->SPACE.
//    SPACE: ->REQ when CAPACITY-occupancy >= BW; otherwise hold.
//    REQ  : dma_req=1 until dma_ack; on ack, beat_cnt=0, bursts_left--, ->XFER.
//    XFER : each dma_beat_valid increments beat_cnt.
//           On the beat where beat_cnt==BURST_LENGTH-1: ->SPACE if bursts_left!=0, else ->DRAIN.
//    DRAIN: ->DONE when occupancy==0.
//    DONE : done=1 for exactly one cycle, ->IDLE.
//  - Only one burst is outstanding at a time. start outside IDLE is ignored.
//  - buf_wen = dma_beat_valid & (state==XFER) & ~ovf.
//    ovf = occupancy+NUM_LANE > CAPACITY after applying this cycle's consume.
//    A beat with ovf asserted sets err_overflow and is dropped. beat_cnt still advances.
//    Beats outside XFER are ignored and do not count.
//  - Occupancy next = occ + (buf_wen ? NUM_LANE : 0) - (buf_consume & occ!=0 ? 1 : 0).
//    Simultaneous write and consume apply both in the same cycle.
//    Consume at occ==0 is ignored, and occupancy never wraps.
//  - err_overflow clears only on rst.
//  - done and busy are registered outputs. buf_wen has zero latency. The REQ->XFER transition
//    takes 1 cycle after dma_ack.
// CONFIGURATION
//  RING_CTRL_PERF_EN defined:
//    perf_stall_cyc counts cycles spent in SPACE, saturating at 2^32-1.
//    Cleared on rst and on an accepted start.
//  RING_CTRL_PERF_EN undefined:
//    perf_stall_cyc is tied to 0 and no counter logic is built.
// TESTING  (NUM_LANE=4, BURST_LENGTH=8, CAPACITY=64, BW=32)
//  - Reset: assert rst mid-XFER -> busy=0, dma_req=0, occupancy=0, same cycle (async).
//  - start, total_bursts=2, dma_ack immediate, 8 beats each, consume=0:
//    -> 2 dma_req, occupancy=64, FSM holds in DRAIN.
//    Then 64 consumes -> done pulses once, busy drops.
//  - total_bursts=3, no consume: burst 3 stalls in SPACE with dma_req=0.
//    Each consume raises free space; dma_req rises only once occupancy<=32.
//    perf_stall_cyc>0 with the macro defined, 0 without.
//  - Write and consume in the same cycle at occupancy=10 -> occupancy=13.
//    Consume at occupancy=0 -> stays 0.
//  - Force beats until occupancy=62, then one more beat -> err_overflow=1, buf_wen=0,
//    occupancy stays 62.
//  - start with total_bursts=0 -> done pulses 2 cycles after start, no dma_req.
//    start while busy -> ignored.

Source files
------------

// File: rtl/ring_buffer_burst_ctrl.sv
// ============================================================================
// ring_buffer_burst_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Sequences DMA bursts into the first-stage lane ring buffer. A burst is
//   requested only when the ring has room for a whole burst
//   (NUM_LANE*BURST_LENGTH words). Beats are counted up to BURST_LENGTH.
//   Word occupancy is tracked from lane writes and single-word reads. A
//   one-cycle done pulse is issued once every burst has been written and the
//   ring has drained.
//
// Optional feature macro:
//   RING_CTRL_PERF_EN : when defined, perf_stall_cyc counts the cycles spent
//                       waiting for ring space. The count saturates, and it
//                       is cleared on rst and on an accepted start. When the
//                       macro is undefined, the output is tied to 0.
//
// Ports:
//   clk             in   clock
//   rst             in   asynchronous reset, active-high
//   start           in   begin-job pulse, honoured only in IDLE
//   total_bursts    in   bursts in the job, latched on an accepted start
//   busy            out  registered, high whenever the FSM is not in IDLE
//   done            out  registered single-cycle job-completion pulse
//   dma_req         out  burst request, held until dma_ack
//   dma_ack         in   DMA accepted the request
//   dma_beat_valid  in   one NUM_LANE-word beat from the DMA this cycle
//   buf_wen         out  ring write enable (combinational, zero latency)
//   buf_consume     in   one word read from the ring this cycle
//   occupancy       out  words currently held in the ring
//   err_overflow    out  sticky, a beat arrived with no room and was dropped
//   perf_stall_cyc  out  stall-cycle counter (see macro above)
// ============================================================================
module ring_buffer_burst_ctrl #(
    parameter int NUM_LANE     = 4,
    parameter int BURST_LENGTH = 128,
    parameter int CAPACITY     = 512,
    parameter int CNT_W        = 16,
    localparam int OCC_W       = $clog2(CAPACITY) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] total_bursts,
    output logic             busy,
    output logic             done,
    output logic             dma_req,
    input  logic             dma_ack,
    input  logic             dma_beat_valid,
    output logic             buf_wen,
    input  logic             buf_consume,
    output logic [OCC_W-1:0] occupancy,
    output logic             err_overflow,
    output logic [31:0]      perf_stall_cyc
);

    localparam int BW     = NUM_LANE * BURST_LENGTH;
    localparam int BEAT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

    // The capacity arithmetic uses one extra bit, so "occupancy + lane" can
    // never wrap before it is compared against the capacity.
    localparam logic [OCC_W:0]    CAP_X  = (OCC_W+1)'(CAPACITY);
    localparam logic [OCC_W:0]    BW_X   = (OCC_W+1)'(BW);
    localparam logic [OCC_W:0]    LANE_X = (OCC_W+1)'(NUM_LANE);
    localparam logic [OCC_W-1:0]  LANE_O = OCC_W'(NUM_LANE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPACE,
        S_REQ,
        S_XFER,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_bursts_left;
    logic [BEAT_W-1:0] r_beat_cnt;

    logic              w_start_acc;
    logic              w_consume;
    logic [OCC_W-1:0]  w_occ_dec;
    logic              w_ovf;
    logic              w_wen;
    logic              w_space_ok;
    logic              w_dma_req;

    assign w_start_acc = start && (r_state == S_IDLE);

    // A read from an empty ring is ignored, so occupancy never wraps below 0.
    assign w_consume = buf_consume && (r_occ != '0);
    assign w_occ_dec = r_occ - OCC_W'(w_consume);

    // The overflow test uses the occupancy after this cycle's read. A beat
    // that lands in the same cycle as a read can therefore use the freed word.
    assign w_ovf      = ({1'b0, w_occ_dec} + LANE_X) > CAP_X;
    assign w_wen      = dma_beat_valid && (r_state == S_XFER) && !w_ovf;
    assign w_space_ok = (CAP_X - {1'b0, r_occ}) >= BW_X;

    always_comb begin
        w_state_next = r_state;
        w_dma_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (total_bursts == '0) ? S_DONE : S_SPACE;
                end
            end
            S_SPACE: begin
                if (w_space_ok) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_dma_req = 1'b1;
                if (dma_ack) begin
                    w_state_next = S_XFER;
                end
            end
            S_XFER: begin
                // bursts_left was already decremented when the request was
                // acknowledged. A value of 0 here means this is the last burst.
                if (dma_beat_valid && (r_beat_cnt == LAST_BEAT)) begin
                    w_state_next = (r_bursts_left != '0) ? S_SPACE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_occ == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_occ         <= '0;
            r_bursts_left <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            // busy is registered from the next state, so it tracks the state
            // register exactly. done is registered from the DONE state, so it
            // appears on the cycle after DONE, as the FSM returns to IDLE.
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (r_state == S_DONE);
            r_occ   <= w_occ_dec + (w_wen ? LANE_O : '0);

            if (w_start_acc) begin
                r_bursts_left <= total_bursts;
            end else if ((r_state == S_REQ) && dma_ack) begin
                r_bursts_left <= r_bursts_left - CNT_W'(1);
            end

            // A dropped beat still advances the count, so the burst framing
            // stays aligned with the DMA.
            if ((r_state == S_REQ) && dma_ack) begin
                r_beat_cnt <= '0;
            end else if ((r_state == S_XFER) && dma_beat_valid) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end

            if ((r_state == S_XFER) && dma_beat_valid && w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef RING_CTRL_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_start_acc) begin
            r_perf <= '0;
        end else if ((r_state == S_SPACE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_stall_cyc = r_perf;
`else
    assign perf_stall_cyc = 32'd0;
`endif

    assign busy         = r_busy;
    assign done         = r_done;
    assign dma_req      = w_dma_req;
    assign buf_wen      = w_wen;
    assign occupancy    = r_occ;
    assign err_overflow = r_err;

endmodule
